aes_out_serializer: RTL and testbench

- Downstream of AES_top. Captures each 128-bit ciphertext on the rising edge of AES_data_out_valid into a small FIFO.
- Drains the FIFO as four 32-bit words over a valid/ready stream for the bus/UART-side consumer.
- Decouples AES_top, which holds AES_data_out_valid high for many cycles, from a consumer that may stall.

---
 rtl/aes_out_serializer.sv | 136 +++++++++++++
 tb/tb_aes_out_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_serializer.sv
// ============================================================================
// Module   : aes_out_serializer
// Purpose  : Captures AES_top ciphertext blocks into a small FIFO and streams
//            them out as 32-bit words over valid/ready.
//            Optional even-parity output: define AES_SER_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_out_serializer #(
    parameter int DEPTH     = 2,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic                     AES_clk,
    input  logic                     AES_rst_n,
    input  logic                     AES_data_out_valid,
    input  logic [127:0]             AES_data_out,
    output logic [31:0]              ser_data,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_last,
    output logic                     ser_overflow,
    input  logic                     ser_clr_ovf,
`ifdef AES_SER_PARITY_EN
    output logic                     ser_parity,
`endif
    output logic [$clog2(DEPTH):0]   ser_fill
);

    localparam int                PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                FILL_W      = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0]  c_last_ptr  = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] c_full_fill = FILL_W'(DEPTH);

    logic [127:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_fill;
    logic [1:0]        r_idx;
    logic              r_valid_d;
    logic              r_ovf;

    logic              w_cap;
    logic              w_full;
    logic              w_hs;
    logic              w_pop;
    logic              w_wr;
    logic [1:0]        w_sel;
    logic [127:0]      w_head;

    assign w_cap  = AES_data_out_valid & ~r_valid_d;
    assign w_full = (r_fill == c_full_fill);
    assign w_hs   = ser_valid & ser_ready;
    assign w_pop  = w_hs & (r_idx == 2'd3);
    // A full FIFO still accepts a block when its head is retiring on the same edge.
    assign w_wr   = w_cap & (~w_full | w_pop);

    // MSW-first walks the block from the top word down (3 - idx).
    assign w_sel  = MSW_FIRST ? ~r_idx : r_idx;
    assign w_head = r_mem[r_rd_ptr];

    assign ser_valid    = (r_fill != '0);
    assign ser_data     = ser_valid ? w_head[{w_sel, 5'b0} +: 32] : 32'h0;
    assign ser_last     = ser_valid & (r_idx == 2'd3);
    assign ser_overflow = r_ovf;
    assign ser_fill     = r_fill;

    always_ff @(posedge AES_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= AES_data_out;
        end
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_valid_d <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_idx     <= 2'd0;
            r_ovf     <= 1'b0;
        end else begin
            r_valid_d <= AES_data_out_valid;

            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end

            if (w_hs) begin
                r_idx <= r_idx + 2'd1;
            end

            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end

            case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase

            // A fresh drop outranks a simultaneous clear.
            if (w_cap & w_full & ~w_pop) begin
                r_ovf <= 1'b1;
            end else if (ser_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef AES_SER_PARITY_EN
    logic [3:0] r_par [DEPTH];
    logic [3:0] w_cap_par;
    logic [3:0] w_head_par;

    always_comb begin
        w_cap_par = 4'b0;
        for (int k = 0; k < 4; k++) begin
            w_cap_par[k] = ^AES_data_out[k*32 +: 32];
        end
    end

    always_ff @(posedge AES_clk) begin
        if (w_wr) begin
            r_par[r_wr_ptr] <= w_cap_par;
        end
    end

    assign w_head_par = r_par[r_rd_ptr];
    assign ser_parity = ser_valid & w_head_par[w_sel];
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_out_serializer.sv
// ============================================================================
// Module   : tb_aes_out_serializer
// Purpose  : Directed bench for aes_out_serializer (MSW-first and LSW-first).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_out_serializer;

    logic         clk;
    logic         rst_n;
    logic         valid_a, ready_a, clr_a;
    logic [127:0] data_a;
    logic [31:0]  sdata_a;
    logic         svalid_a, slast_a, sovf_a;
    logic [1:0]   sfill_a;
    logic         valid_b, ready_b, clr_b;
    logic [127:0] data_b;
    logic [31:0]  sdata_b;
    logic         svalid_b, slast_b, sovf_b;
    logic [1:0]   sfill_b;
`ifdef AES_SER_PARITY_EN
    logic         spar_a, spar_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] c_blk1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] c_blk6 = 128'h00000001_00000003_00000000_ffffffff;
    localparam logic [127:0] c_a5   = {4{32'ha5a5a5a5}};

    logic [31:0] w1 [4];

    aes_out_serializer #(.DEPTH(2), .MSW_FIRST(1'b1)) dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_data_out_valid (valid_a),
        .AES_data_out       (data_a),
        .ser_data           (sdata_a),
        .ser_valid          (svalid_a),
        .ser_ready          (ready_a),
        .ser_last           (slast_a),
        .ser_overflow       (sovf_a),
        .ser_clr_ovf        (clr_a),
`ifdef AES_SER_PARITY_EN
        .ser_parity         (spar_a),
`endif
        .ser_fill           (sfill_a)
    );

    aes_out_serializer #(.DEPTH(2), .MSW_FIRST(1'b0)) dut_lsw (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_data_out_valid (valid_b),
        .AES_data_out       (data_b),
        .ser_data           (sdata_b),
        .ser_valid          (svalid_b),
        .ser_ready          (ready_b),
        .ser_last           (slast_b),
        .ser_overflow       (sovf_b),
        .ser_clr_ovf        (clr_b),
`ifdef AES_SER_PARITY_EN
        .ser_parity         (spar_b),
`endif
        .ser_fill           (sfill_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        int k;
        w1[0] = 32'h69c4e0d8; w1[1] = 32'h6a7b0430;
        w1[2] = 32'hd8cdb780; w1[3] = 32'h70b4c55a;

        rst_n = 1'b0;
        valid_a = 1'b0; ready_a = 1'b0; clr_a = 1'b0; data_a = '0;
        valid_b = 1'b0; ready_b = 1'b0; clr_b = 1'b0; data_b = '0;
        tick(); tick();

        // Reset state
        chk("rst_valid", {31'b0, svalid_a}, 32'd0);
        chk("rst_last",  {31'b0, slast_a},  32'd0);
        chk("rst_ovf",   {31'b0, sovf_a},   32'd0);
        chk("rst_fill",  {30'b0, sfill_a},  32'd0);
        chk("rst_data",  sdata_a,           32'd0);

        // Single block, valid held 50 cycles
        rst_n = 1'b1;
        valid_a = 1'b1; data_a = c_blk1; ready_a = 1'b1;
        tick();
        chk("t1_fill", {30'b0, sfill_a}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", {31'b0, svalid_a}, 32'd1);
            chk("t1_word",  sdata_a, w1[i]);
            chk("t1_last",  {31'b0, slast_a}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t1_fill_end", {30'b0, sfill_a}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 45; i++) begin
            if (svalid_a) cnt++;
            tick();
        end
        chk("t1_no_second_copy", cnt, 32'd0);
        valid_a = 1'b0;
        tick();

        // Backpressure: ready pattern 1,0,0 repeating
        valid_a = 1'b1; data_a = c_blk1; ready_a = 1'b0;
        tick();
        valid_a = 1'b0;
        chk("t2_fill_up", {30'b0, sfill_a}, 32'd1);
        k = 0;
        cnt = 0;
        while (k < 4 && cnt < 20) begin
            chk("t2_word", sdata_a, w1[k]);
            chk("t2_last", {31'b0, slast_a}, (k == 3) ? 32'd1 : 32'd0);
            chk("t2_valid", {31'b0, svalid_a}, 32'd1);
            ready_a = (cnt % 3 == 0);
            tick();
            if (ready_a) k++;
            cnt++;
        end
        chk("t2_words_done", k, 32'd4);
        ready_a = 1'b0;
        chk("t2_fill_down", {30'b0, sfill_a}, 32'd0);

        // Overflow with DEPTH=2, consumer stalled
        for (int i = 1; i <= 3; i++) begin
            valid_a = 1'b1; data_a = 128'(i);
            tick();
            valid_a = 1'b0;
            tick();
        end
        chk("t3_fill", {30'b0, sfill_a}, 32'd2);
        chk("t3_ovf",  {31'b0, sovf_a},  32'd1);
        ready_a = 1'b1;
        for (int b = 1; b <= 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_word", sdata_a, (i == 3) ? 32'(b) : 32'd0);
                tick();
            end
        end
        chk("t3_fill_empty", {30'b0, sfill_a}, 32'd0);
        chk("t3_ovf_sticky", {31'b0, sovf_a},  32'd1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("t3_ovf_clr", {31'b0, sovf_a}, 32'd0);

        // Pop and capture on the same edge with the FIFO full
        ready_a = 1'b0;
        valid_a = 1'b1; data_a = c_blk1;
        tick();
        valid_a = 1'b0;
        tick();
        valid_a = 1'b1; data_a = 128'h2;
        tick();
        valid_a = 1'b0;
        tick();
        chk("t4_full", {30'b0, sfill_a}, 32'd2);
        ready_a = 1'b1;
        tick(); tick(); tick();
        chk("t4_last_head", {31'b0, slast_a}, 32'd1);
        valid_a = 1'b1; data_a = c_a5;
        tick();
        valid_a = 1'b0;
        chk("t4_fill_same", {30'b0, sfill_a}, 32'd2);
        chk("t4_ovf_clear", {31'b0, sovf_a},  32'd0);
        chk("t4_next_head", sdata_a, 32'd0);
        tick(); tick(); tick(); tick();
        chk("t4_a5_word", sdata_a, 32'ha5a5a5a5);
        chk("t4_fill_one", {30'b0, sfill_a}, 32'd1);
        tick(); tick(); tick(); tick();
        chk("t4_drained", {30'b0, sfill_a}, 32'd0);

        // Reset in the middle of a drain
        valid_a = 1'b1; data_a = c_blk1; ready_a = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_pre_rst_word", sdata_a, w1[2]);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'b0, svalid_a}, 32'd0);
        chk("t5_rst_fill",  {30'b0, sfill_a},  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_recap_fill", {30'b0, sfill_a}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_word", sdata_a, w1[i]);
            chk("t5_last", {31'b0, slast_a}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (svalid_a) cnt++;
            tick();
        end
        chk("t5_single_capture", cnt, 32'd0);
        valid_a = 1'b0;

        // LSW-first ordering (and stored parity when enabled)
        valid_b = 1'b1; data_b = c_blk6; ready_b = 1'b1;
        tick();
        valid_b = 1'b0;
        chk("t6_word0", sdata_b, 32'hffffffff);
`ifdef AES_SER_PARITY_EN
        chk("t6_par0", {31'b0, spar_b}, 32'd0);
`endif
        tick();
        chk("t6_word1", sdata_b, 32'h00000000);
`ifdef AES_SER_PARITY_EN
        chk("t6_par1", {31'b0, spar_b}, 32'd0);
`endif
        tick();
        chk("t6_word2", sdata_b, 32'h00000003);
`ifdef AES_SER_PARITY_EN
        chk("t6_par2", {31'b0, spar_b}, 32'd0);
`endif
        tick();
        chk("t6_word3", sdata_b, 32'h00000001);
        chk("t6_last",  {31'b0, slast_b}, 32'd1);
`ifdef AES_SER_PARITY_EN
        chk("t6_par3", {31'b0, spar_b}, 32'd1);
`endif
        tick();
        chk("t6_empty", {30'b0, sfill_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
